// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that shares one signed Booth multiplier engine among R requesters.
// Sequences start/latency/capture for the engine and returns each product tagged with its requester.
module mult_rr_arbiter #(
  parameter int N = 5,
  parameter int R = 4,
  localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [R-1:0]          req_valid,
  input  logic [R*N-1:0]        req_a,
  input  logic [R*N-1:0]        req_b,
  output logic [R-1:0]          req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic signed [2*N-1:0] resp_product,
  output logic                  busy,
  output logic                  mul_start,
  output logic signed [N-1:0]   mul_multiplier,
  output logic signed [N-1:0]   mul_multiplicand,
  input  logic signed [2*N-1:0] mul_product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  cnt;
  logic [R-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  int             scan_idx;

  // Cyclic priority search starting just after the last granted requester.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    if (rstn && state_q == IDLE) begin
      for (int k = 1; k <= R; k++) begin
        scan_idx = (int'(ptr) + k) % R;
        if (!grant_found && req_valid[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(scan_idx);
        end
      end
      if (grant_found) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = START;
      START:   state_d = RUN;
      RUN:     if (cnt == CW'(N)) state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand latch on grant, latency count, product capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr              <= IDW'(R - 1);
      id_q             <= '0;
      cnt              <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      resp_id          <= '0;
      resp_product     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            mul_multiplier   <= req_a[int'(grant_idx)*N +: N];
            mul_multiplicand <= req_b[int'(grant_idx)*N +: N];
            id_q             <= grant_idx;
            ptr              <= grant_idx;
          end
        end
        START: cnt <= '0;
        RUN:   cnt <= cnt + 1'b1;
        CAPT: begin
          resp_product <= mul_product;
          resp_id      <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = grant;
  assign mul_start  = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a fixed-latency engine model (N=5, R=4).
module tb_mult_rr_arbiter;
  localparam int N = 5;
  localparam int R = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [R-1:0]      req_valid;
  logic [R*N-1:0]    req_a;
  logic [R*N-1:0]    req_b;
  logic [R-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic signed [9:0] resp_product;
  logic              busy;
  logic              mul_start;
  logic signed [4:0] mul_multiplier;
  logic signed [4:0] mul_multiplicand;
  logic signed [9:0] mul_product;

  int vec = 0;
  int errs = 0;
  int eng_cnt;

  always #5 clk = ~clk;

  mult_rr_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .busy(busy), .mul_start(mul_start),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product)
  );

  // Engine model: product registered N+1 edges after the edge that samples start; junk before.
  always @(posedge clk) begin
    if (!rstn) begin
      eng_cnt     <= 0;
      mul_product <= '0;
    end else if (mul_start) begin
      eng_cnt     <= N + 1;
      mul_product <= 10'h2AA;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt     <= 0;
      mul_product <= $signed(mul_multiplier) * $signed(mul_multiplicand);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rstn = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    req_valid = 4'hF;
    #1;
    vec++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vec++; if (mul_start !== 1'b0) begin errs++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
    vec++; if (resp_id !== 2'd0) begin errs++; $display("FAIL reset_resp_id got %0d want 0", resp_id); end
    vec++; if (resp_product !== 10'h000) begin errs++; $display("FAIL reset_resp_product got %h want 000", resp_product); end
    vec++; if (mul_multiplier !== 5'h00 || mul_multiplicand !== 5'h00) begin
      errs++; $display("FAIL reset_operands got %h/%h want 00/00", mul_multiplier, mul_multiplicand);
    end
    req_valid = '0;
    rstn = 1'b1;
  endtask

  task automatic test_single;
    apply_reset();
    req_a[2*N +: N] = 5'd3;
    req_b[2*N +: N] = 5'h1C;
    req_valid = 4'b0100;
    #1;
    vec++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_grant got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    vec++; if (mul_start !== 1'b1) begin errs++; $display("FAIL single_start_c1 got %b want 1", mul_start); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy_c1 got %b want 1", busy); end
    vec++; if (mul_multiplier !== 5'd3 || mul_multiplicand !== 5'h1C) begin
      errs++; $display("FAIL single_operands got %h/%h want 03/1c", mul_multiplier, mul_multiplicand);
    end
    for (int c = 2; c <= 8; c++) begin
      tick();
      vec++; if (mul_start !== 1'b0 || resp_valid !== 1'b0) begin
        errs++; $display("FAIL single_cycle%0d start=%b resp_valid=%b want 0/0", c, mul_start, resp_valid);
      end
    end
    tick();
    vec++; if (resp_valid !== 1'b1) begin errs++; $display("FAIL single_resp_valid_c9 got %b want 1", resp_valid); end
    vec++; if (resp_product !== 10'h3F4) begin errs++; $display("FAIL single_product got %h want 3f4", resp_product); end
    vec++; if (resp_id !== 2'd2) begin errs++; $display("FAIL single_id got %0d want 2", resp_id); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    vec++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errs++; $display("FAIL single_idle_c10 busy=%b resp_valid=%b want 0/0", busy, resp_valid);
    end
  endtask

  task automatic run_op(input int id, input logic [4:0] a, input logic [4:0] b, input logic [9:0] exp);
    bit got;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    resp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      #1;
      if (req_ready[id]) got = 1;
      else tick();
    end
    vec++; if (!got) begin errs++; $display("FAIL op%0d_grant timeout got no grant want grant", id); end
    tick();
    req_valid = '0;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (resp_valid) got = 1;
      else tick();
    end
    vec++;
    if (!got) begin
      errs++; $display("FAIL op%0d_resp timeout got no resp_valid want resp_valid", id);
    end else if (resp_product !== exp || resp_id !== 2'(id)) begin
      errs++; $display("FAIL op%0d_result got %h id %0d want %h id %0d", id, resp_product, resp_id, exp, id);
    end
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_extreme;
    apply_reset();
    run_op(0, 5'h10, 5'h10, 10'h100);
    run_op(3, 5'h07, 5'h05, 10'h023);
    run_op(1, 5'h0F, 5'h10, 10'h310);
    run_op(2, 5'h1F, 5'h1F, 10'h001);
  endtask

  task automatic test_round_robin;
    int gcyc[$];
    int gid[$];
    int rid[$];
    logic [9:0] rprod[$];
    logic [9:0] exp_tab [4];
    exp_tab[0] = 10'h3FE; exp_tab[1] = 10'h3FA; exp_tab[2] = 10'h3F4; exp_tab[3] = 10'h3EC;
    apply_reset();
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = 5'(i + 1);
      req_b[i*N +: N] = 5'(-(i + 2));
    end
    req_valid = 4'hF;
    resp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      for (int i = 0; i < R; i++) if (req_ready[i]) begin gcyc.push_back(c); gid.push_back(i); end
      if (resp_valid) begin rid.push_back(int'(resp_id)); rprod.push_back(resp_product); end
      tick();
    end
    req_valid = '0;
    resp_ready = 1'b0;
    vec++;
    if (gid.size() < 5 || rid.size() < 5) begin
      errs++; $display("FAIL rr_count got %0d grants %0d resps want 5/5", gid.size(), rid.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vec++; if (gid[k] !== k % 4) begin errs++; $display("FAIL rr_grant%0d got %0d want %0d", k, gid[k], k % 4); end
        vec++; if (rid[k] !== k % 4 || rprod[k] !== exp_tab[k%4]) begin
          errs++; $display("FAIL rr_resp%0d got id %0d %h want id %0d %h", k, rid[k], rprod[k], k % 4, exp_tab[k%4]);
        end
        if (k > 0) begin
          vec++; if (gcyc[k] - gcyc[k-1] !== 10) begin
            errs++; $display("FAIL rr_spacing%0d got %0d want 10", k, gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    bit got;
    apply_reset();
    req_a[1*N +: N] = 5'h10;
    req_b[1*N +: N] = 5'h07;
    req_valid = 4'b0010;
    #1;
    vec++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_grant got %b want 0010", req_ready); end
    tick();
    req_valid = 4'hF;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (resp_valid) got = 1;
      else tick();
    end
    vec++; if (!got) begin errs++; $display("FAIL bp_resp timeout got no resp_valid want resp_valid"); end
    for (int c = 0; c < 20; c++) begin
      vec++;
      if (resp_valid !== 1'b1 || resp_product !== 10'h390 || resp_id !== 2'd1 ||
          req_ready !== 4'b0000 || mul_start !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold%0d got v=%b p=%h id=%0d rdy=%b st=%b want 1 390 1 0000 0",
                 c, resp_valid, resp_product, resp_id, req_ready, mul_start);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    vec++; if (req_ready !== 4'b0100 || resp_valid !== 1'b0) begin
      errs++; $display("FAIL bp_next_grant got rdy=%b v=%b want 0100 0", req_ready, resp_valid);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    bit got;
    apply_reset();
    req_a[2*N +: N] = 5'd3;
    req_b[2*N +: N] = 5'd3;
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    tick();
    req_valid = '0;
    for (int c = 2; c <= 5; c++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    vec++; if (busy !== 1'b0 || resp_valid !== 1'b0 || mul_start !== 1'b0) begin
      errs++; $display("FAIL mid_reset_outputs got busy=%b v=%b st=%b want 0 0 0", busy, resp_valid, mul_start);
    end
    vec++; if (mul_multiplier !== 5'h00) begin
      errs++; $display("FAIL mid_reset_operand got %h want 00", mul_multiplier);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (resp_valid) seen = 1;
      tick();
    end
    vec++; if (seen) begin errs++; $display("FAIL mid_reset_ghost got resp_valid want none"); end
    req_a[0 +: N] = 5'h07;
    req_b[0 +: N] = 5'h05;
    req_a[3*N +: N] = 5'h01;
    req_b[3*N +: N] = 5'h01;
    req_valid = 4'b1001;
    #1;
    vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_reset_priority got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (resp_valid) got = 1;
      else tick();
    end
    vec++; if (!got || resp_product !== 10'h023 || resp_id !== 2'd0) begin
      errs++; $display("FAIL mid_reset_followup got v=%b %h id %0d want 1 023 id 0", got, resp_product, resp_id);
    end
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_fairness;
    int gid[$];
    int exp_seq [3];
    exp_seq[0] = 1; exp_seq[1] = 3; exp_seq[2] = 1;
    apply_reset();
    req_a = '0;
    req_b = '0;
    req_valid = 4'b1010;
    resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int i = 0; i < R; i++) if (req_ready[i]) gid.push_back(i);
      tick();
    end
    req_valid = '0;
    resp_ready = 1'b0;
    vec++;
    if (gid.size() < 3) begin
      errs++; $display("FAIL fair_count got %0d grants want 3", gid.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vec++; if (gid[k] !== exp_seq[k]) begin errs++; $display("FAIL fair_grant%0d got %0d want %0d", k, gid[k], exp_seq[k]); end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_extreme();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
